// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch/decode block:
// FSM states, opcodes and the {nia, branch} PC-control encodings.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, DEC, ADV} state_t;

  localparam logic [3:0] JMP_OP = 4'hC;
  localparam logic [3:0] BEQ_OP = 4'hD;

  localparam logic [1:0] HOLD = 2'b10;
  localparam logic [1:0] SEQ  = 2'b01;
  localparam logic [1:0] JMP  = 2'b00;
  localparam logic [1:0] REL  = 2'b11;

endpackage

// File: rtl/fetch_decoder.sv
// Combinational decode of a fetched instruction (plus zero flag) into the
// PC control pair {nia, branch} and the PC immediate.
module fetch_decoder
  import fetch_pkg::*;
#(
  parameter int AW = 8,
  parameter int IW = 16
) (
  input  logic [IW-1:0] instr,
  input  logic          flag_z,
  output logic          nia,
  output logic          branch,
  output logic [AW-1:0] im
);

  logic [3:0] op;
  logic [1:0] ctl;
  logic       unused_bits;

  assign op          = instr[IW-1:IW-4];
  assign unused_bits = ^instr[IW-5:AW];

  always_comb begin
    ctl = SEQ;
    im  = '0;
    if (op == JMP_OP) begin
      ctl = JMP;
      im  = instr[AW-1:0];
    end else if (op == BEQ_OP && flag_z) begin
      ctl = REL;
      im  = instr[AW-1:0];
    end
  end

  assign {nia, branch} = ctl;

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetches the instruction at the PC over req/ack, hands it downstream with
// valid/ready and steers the PC. FETCH_TIMEOUT_EN adds the ack timeout/retry.
module instr_fetch_decode
  import fetch_pkg::*;
#(
  parameter int AW       = 8,
  parameter int IW       = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_addr,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [IW-1:0] mem_rdata,
  input  logic          flag_z,
  output logic [IW-1:0] instr,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [AW-1:0] im,
  output logic          branch,
  output logic          nia,
  output logic          fetch_err
);

  state_t          state;
  logic            dec_nia;
  logic            dec_branch;
  logic [AW-1:0]   dec_im;

  fetch_decoder #(.AW(AW), .IW(IW)) u_dec (
    .instr  (instr),
    .flag_z (flag_z),
    .nia    (dec_nia),
    .branch (dec_branch),
    .im     (dec_im)
  );

  // Address the PC will hold after this edge; lets the first REQ cycle after
  // ADV present the updated PC even though mem_addr is registered.
  function automatic logic [AW-1:0] pc_after(input logic [AW-1:0] pc,
                                             input logic [1:0]    ctl,
                                             input logic [AW-1:0] off);
    case (ctl)
      SEQ:     return pc + AW'(1);
      JMP:     return off;
      REL:     return pc + off;
      default: return pc;
    endcase
  endfunction

`ifdef FETCH_TIMEOUT_EN
  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  logic [WCW-1:0] wait_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = ^MAX_WAIT;
  assign fetch_err  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_addr    <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      im          <= '0;
      nia         <= 1'b1;
      branch      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_cnt    <= '0;
      fetch_err   <= 1'b0;
`endif
    end else begin
      mem_addr <= pc_after(pc_addr, {nia, branch}, im);
      case (state)
        IDLE: begin
          mem_req <= 1'b1;
          state   <= REQ;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        REQ: begin
          if (mem_ack) begin
            instr       <= mem_rdata;
            instr_valid <= 1'b1;
            mem_req     <= 1'b0;
            state       <= DEC;
          end
`ifdef FETCH_TIMEOUT_EN
          // Timeout drops mem_req for one cycle via IDLE, then retries the same PC.
          else if (wait_cnt == WCW'(MAX_WAIT - 1)) begin
            fetch_err <= 1'b1;
            mem_req   <= 1'b0;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
`endif
        end
        DEC: begin
          if (instr_ready) begin
            {nia, branch} <= {dec_nia, dec_branch};
            im            <= dec_im;
            instr_valid   <= 1'b0;
            state         <= ADV;
          end
        end
        ADV: begin
          {nia, branch} <= HOLD;
          im            <= '0;
          mem_req       <= 1'b1;
          state         <= REQ;
`ifdef FETCH_TIMEOUT_EN
          wait_cnt      <= '0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: a PC and an instruction memory
// around the DUT, a transaction-level reference model, directed then random stimulus.
module tb_instr_fetch_decode;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc_addr;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic        flag_z = 1'b0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [7:0]  im;
  logic        branch;
  logic        nia;
  logic        fetch_err;

  always #5 clk = ~clk;

  instr_fetch_decode #(.AW(8), .IW(16), .MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_addr     (pc_addr),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .flag_z      (flag_z),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .im          (im),
    .branch      (branch),
    .nia         (nia),
    .fetch_err   (fetch_err)
  );

  // Program counter driven by the DUT's control outputs.
  always @(posedge clk or negedge rst) begin
    if (!rst) pc_addr <= 8'h00;
    else begin
      case ({nia, branch})
        2'b01:   pc_addr <= pc_addr + 8'd1;
        2'b00:   pc_addr <= im;
        2'b11:   pc_addr <= pc_addr + im;
        default: pc_addr <= pc_addr;
      endcase
    end
  end

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  // Reference model: architectural PC plus which part of the fetch is in progress.
  bit          m_idle, m_req, m_valid, m_adv, m_err;
  logic [15:0] m_instr;
  logic [1:0]  m_ctl;
  logic [7:0]  m_im, m_pc, m_pc_next;
  int          m_wcnt;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 1; m_req = 0; m_valid = 0; m_adv = 0; m_err = 0;
    m_instr = '0; m_ctl = 2'b10; m_im = '0; m_pc = '0; m_pc_next = '0; m_wcnt = 0;
  endtask

  task automatic model_edge();
    logic [7:0] off;
    if (!rst) model_reset();
    else if (m_adv) begin
      m_pc = m_pc_next; m_adv = 0; m_ctl = 2'b10; m_im = '0; m_req = 1; m_wcnt = 0;
    end else if (m_idle) begin
      m_idle = 0; m_req = 1; m_wcnt = 0;
    end else if (m_req) begin
      if (mem_ack) begin
        m_instr = mem[m_pc]; m_req = 0; m_valid = 1;
      end
`ifdef FETCH_TIMEOUT_EN
      else if (m_wcnt == MAX_WAIT - 1) begin
        m_err = 1; m_req = 0; m_idle = 1;
      end else m_wcnt++;
`endif
    end else if (m_valid && instr_ready) begin
      off = m_instr[7:0];
      if (m_instr[15:12] == 4'hC) begin
        m_ctl = 2'b00; m_im = off; m_pc_next = off;
      end else if (m_instr[15:12] == 4'hD && flag_z) begin
        m_ctl = 2'b11; m_im = off; m_pc_next = m_pc + off;
      end else begin
        m_ctl = 2'b01; m_im = 8'h00; m_pc_next = m_pc + 8'd1;
      end
      m_valid = 0; m_adv = 1;
    end
  endtask

  task automatic compare();
    check("mem_req", 32'(mem_req), 32'(m_req));
    if (m_req) check("mem_addr", 32'(mem_addr), 32'(m_pc));
    check("instr_valid", 32'(instr_valid), 32'(m_valid));
    check("instr", 32'(instr), 32'(m_instr));
    check("nia_branch", 32'({nia, branch}), 32'(m_ctl));
    check("im", 32'(im), 32'(m_im));
    check("fetch_err", 32'(fetch_err), 32'(m_err));
    check("pc_addr", 32'(pc_addr), 32'(m_pc));
  endtask

  task automatic drive(input bit ack, input bit rdy, input bit z);
    mem_ack     = ack;
    mem_rdata   = ack ? mem[mem_addr] : 16'($urandom);
    instr_ready = rdy;
    flag_z      = z;
  endtask

  // One clock: edge, inputs for the new cycle, then compare at the falling edge.
  task automatic cyc(input bit ack, input bit rdy, input bit z);
    @(posedge clk); model_edge(); #1;
    drive(ack, rdy, z);
    @(negedge clk); compare();
  endtask

  task automatic do_reset();
    @(posedge clk); model_edge(); #1;
    rst = 1'b0;
    model_reset();
    drive(1, 1, 1);
    @(negedge clk); compare();
    cyc(0, 0, 0);
  endtask

  task automatic do_release();
    @(posedge clk); model_edge(); #1;
    rst = 1'b1;
    drive(1, 0, 0);
    @(negedge clk); compare();
    check("idle_no_req", 32'(mem_req), 32'd0);
  endtask

  task automatic insn(input int wait_n, input int bp_n, input bit z,
                      input logic [7:0] exp_addr, input logic [15:0] exp_word);
    for (int i = 0; i <= wait_n; i++) begin
      cyc(i == wait_n, 0, !z);
      if (i == 0) begin
        check("req_lit", 32'(mem_req), 32'd1);
        check("addr_lit", 32'(mem_addr), 32'(exp_addr));
      end
    end
    for (int i = 0; i < bp_n; i++) begin
      cyc(0, 0, !z);
      check("bp_instr", 32'(instr), 32'(exp_word));
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_hold", 32'({nia, branch}), 32'h2);
      check("bp_noreq", 32'(mem_req), 32'd0);
    end
    cyc(0, 1, z);
    check("dec_instr", 32'(instr), 32'(exp_word));
    check("dec_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic adv(input logic [1:0] ctl, input logic [7:0] imv);
    cyc(0, 1, 0);
    check("adv_ctl", 32'({nia, branch}), 32'(ctl));
    check("adv_im", 32'(im), 32'(imv));
    check("adv_valid", 32'(instr_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       w[15:12] = 4'hC;
        1:       w[15:12] = 4'hD;
        default: ;
      endcase
      mem[i] = w;
    end
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'hC040;
    mem[8'h40] = 16'hC010;
    mem[8'h10] = 16'hD0FE;
    mem[8'h0E] = 16'hC010;
    mem[8'h11] = 16'h0000;

    #1 rst = 1'b0;
    model_reset();
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_im", 32'(im), 32'd0);
    check("rst_nia", 32'(nia), 32'd1);
    check("rst_branch", 32'(branch), 32'd0);
    check("rst_err", 32'(fetch_err), 32'd0);

    do_release();
    insn(2, 0, 0, 8'h00, 16'h1234);
    adv(2'b01, 8'h00);
    insn(0, 0, 0, 8'h01, 16'hC040);
    adv(2'b00, 8'h40);
    insn(1, 0, 0, 8'h40, 16'hC010);
    adv(2'b00, 8'h10);
    insn(0, 0, 1, 8'h10, 16'hD0FE);
    adv(2'b11, 8'hFE);
    insn(0, 0, 0, 8'h0E, 16'hC010);
    adv(2'b00, 8'h10);
    insn(0, 5, 0, 8'h10, 16'hD0FE);
    adv(2'b01, 8'h00);
    insn(0, 0, 0, 8'h11, 16'h0000);
    adv(2'b01, 8'h00);

    // Reset in the REQ cycle at 0x12 while mem_ack is high.
    do_reset();
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_valid", 32'(instr_valid), 32'd0);
    check("mid_rst_ctl", 32'({nia, branch}), 32'h2);
    check("mid_rst_pc", 32'(pc_addr), 32'd0);
    do_release();
    check("stray_ack_instr", 32'(instr), 32'd0);

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < MAX_WAIT; i++) begin
      cyc(0, 1, 0);
      check("to_req", 32'(mem_req), 32'd1);
      check("to_err0", 32'(fetch_err), 32'd0);
    end
    cyc(1, 1, 0);
    check("to_gap", 32'(mem_req), 32'd0);
    check("to_err1", 32'(fetch_err), 32'd1);
    mem_ack = 1'b0;
    cyc(1, 1, 0);
    check("to_retry_req", 32'(mem_req), 32'd1);
    check("to_retry_addr", 32'(mem_addr), 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0);
      check("wait_req", 32'(mem_req), 32'd1);
    end
    cyc(1, 1, 0);
`endif
    cyc(0, 1, 0);
    check("late_instr", 32'(instr), 32'h1234);
`ifdef FETCH_TIMEOUT_EN
    check("err_sticky", 32'(fetch_err), 32'd1);
`endif

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
        do_release();
      end else begin
        cyc($urandom_range(0, 99) < 45, $urandom_range(0, 99) < 60, 1'($urandom_range(0, 1)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
